// File: rtl/mux_dec_unit.sv
// Registered 2:1 code mux feeding a 3-to-8 enabled decoder.
// All three outputs come from one register stage, so there is no input-to-output combinational path.
module mux_dec_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in1,
  input  logic [2:0] in2,
  input  logic       select,
  input  logic       en,
  output logic [2:0] mux_out,
  output logic [7:0] dec_out,
  output logic [7:0] not_dec_out
);

  logic [2:0] m;
  logic [7:0] d;

  always_comb begin
    m = select ? in2 : in1;
  end

  // Decode the live mux result, not mux_out, so the code and decode register together.
  always_comb begin
    d = '0;
    if (en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        d[i] = (m == 3'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_out     <= '0;
      dec_out     <= '0;
      not_dec_out <= '1;
    end else begin
      mux_out     <= m;
      dec_out     <= d;
      not_dec_out <= ~d;
    end
  end

endmodule

// File: tb/tb_mux_dec_unit.sv
// Self-checking bench for mux_dec_unit: directed cases, an exhaustive sweep with a mid-stream reset,
// and a randomized phase, all compared against a behavioural model of the registered outputs.
module tb_mux_dec_unit;

  logic       clk;
  logic       rst;
  logic [2:0] in1;
  logic [2:0] in2;
  logic       select;
  logic       en;
  logic [2:0] mux_out;
  logic [7:0] dec_out;
  logic [7:0] not_dec_out;

  int unsigned n_total;
  int unsigned n_pass;

  // Model of what the output register should hold after the most recent edge.
  logic [2:0] exp_mux;
  logic [7:0] exp_dec;
  bit         have_state;

  mux_dec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in1         (in1),
    .in2         (in2),
    .select      (select),
    .en          (en),
    .mux_out     (mux_out),
    .dec_out     (dec_out),
    .not_dec_out (not_dec_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_val);
    n_total++;
    if (obs !== exp_val) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".mux"}, {5'b0, mux_out}, {5'b0, exp_mux});
    check({tag, ".dec"}, dec_out, exp_dec);
    check({tag, ".ndec"}, not_dec_out, ~exp_dec);
  endtask

  // Drive one cycle of inputs, confirm the outputs do not react before the edge,
  // then advance one edge and compare with the model.
  task automatic apply(input string tag, input logic r, input logic [2:0] a, input logic [2:0] b,
                       input logic s, input logic e);
    int unsigned code;
    rst = r; in1 = a; in2 = b; select = s; en = e;
    #1;
    if (have_state) check_outputs({tag, ".hold"});
    @(posedge clk);
    #1;
    code = s ? int'(b) : int'(a);
    if (r) begin
      exp_mux = '0;
      exp_dec = '0;
    end else begin
      exp_mux = 3'(code);
      exp_dec = e ? 8'(1 << code) : 8'h00;
    end
    have_state = 1'b1;
    check_outputs(tag);
  endtask

  initial begin
    n_total = 0;
    n_pass = 0;
    have_state = 1'b0;
    exp_mux = '0;
    exp_dec = '0;
    rst = 1'b1; in1 = '0; in2 = '0; select = 1'b0; en = 1'b0;

    // Reset held for two edges with arbitrary inputs.
    apply("rst0", 1'b1, 3'($urandom), 3'($urandom), 1'($urandom), 1'b1);
    apply("rst1", 1'b1, 3'($urandom), 3'($urandom), 1'($urandom), 1'b1);

    // Directed cases with explicit constant expectations.
    apply("sel0_en", 1'b0, 3'd0, 3'd7, 1'b0, 1'b1);
    check("sel0_en.dec_k", dec_out, 8'h01);
    apply("dis", 1'b0, 3'd0, 3'd7, 1'b0, 1'b0);
    check("dis.ndec_k", not_dec_out, 8'hFF);
    apply("sel1_en", 1'b0, 3'd0, 3'd7, 1'b1, 1'b1);
    check("sel1_en.dec_k", dec_out, 8'h80);
    check("sel1_en.ndec_k", not_dec_out, 8'h7F);
    apply("dis_sel1", 1'b0, 3'd0, 3'd7, 1'b1, 1'b0);
    check("dis_sel1.mux_k", {5'b0, mux_out}, 8'd7);

    // Exhaustive sweep, with reset asserted across two consecutive vectors mid-sweep.
    for (int v = 0; v < 256; v++) begin
      logic r;
      r = (v == 100 || v == 101);
      apply($sformatf("sw%0d", v), r, 3'(v), 3'(v >> 3), 1'(v >> 6), 1'(v >> 7));
    end

    // Randomized phase with occasional reset.
    for (int k = 0; k < 300; k++) begin
      apply($sformatf("rnd%0d", k), ($urandom_range(0, 15) == 0),
            3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
